// File: rtl/router_sync_pkg.sv
// Shared types, field-offset helpers and hop-code functions for the synchronous mesh router.
package router_sync_pkg;

  localparam int unsigned NPORT  = 5;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned MAXW   = 64;
  localparam int unsigned HOPW   = 32;

  typedef enum logic [PORT_W-1:0] {
    P_W  = 3'd0,
    P_E  = 3'd1,
    P_N  = 3'd2,
    P_S  = 3'd3,
    P_PE = 3'd4
  } port_e;

  // Routing decision for one FIFO head; new_pkt is zero-extended to MAXW.
  typedef struct packed {
    port_e           out_port;
    logic            legal;
    logic [MAXW-1:0] new_pkt;
  } route_t;

  // Payload width.
  function automatic int unsigned pw_of(int unsigned w, int unsigned xh, int unsigned yh);
    return w - 2 - xh - yh;
  endfunction

  // LSB position of the yhop field.
  function automatic int unsigned yhop_lsb(int unsigned w, int unsigned xh, int unsigned yh);
    return pw_of(w, xh, yh);
  endfunction

  // LSB position of the xhop field.
  function automatic int unsigned xhop_lsb(int unsigned w, int unsigned xh, int unsigned yh);
    return pw_of(w, xh, yh) + yh;
  endfunction

  // Right-aligned thermometer code is nonzero iff its LSB is set.
  function automatic logic hop_nz(input logic [HOPW-1:0] h);
    return |(h & HOPW'(1));
  endfunction

  // One hop consumed: logical shift right with zero fill.
  function automatic logic [HOPW-1:0] hop_dec(input logic [HOPW-1:0] h);
    return h >> 1;
  endfunction

  // Round-robin successor of a granted port.
  function automatic logic [PORT_W-1:0] rr_next(input logic [PORT_W-1:0] g);
    return (g == PORT_W'(NPORT - 1)) ? '0 : g + PORT_W'(1);
  endfunction

  // Port visited k steps after base in the round-robin search.
  function automatic logic [PORT_W-1:0] rr_idx(input logic [PORT_W-1:0] base, input int unsigned k);
    return PORT_W'((32'(base) + k) % NPORT);
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// Per-input circular FIFO with synchronous active-high reset; head is the oldest entry.
module router_in_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_mesh_sync.sv
// 5-port XY dimension-order mesh router with input FIFOs, per-output round-robin and registered outputs.
module router_mesh_sync
  import router_sync_pkg::*;
#(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned XH       = 3,
  parameter int unsigned YH       = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int          NODE_NUM = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            in_valid,
  output logic [NPORT-1:0]            in_ready,
  input  logic [NPORT-1:0][WIDTH-1:0] in_data,
  output logic [NPORT-1:0]            out_valid,
  input  logic [NPORT-1:0]            out_ready,
  output logic [NPORT-1:0][WIDTH-1:0] out_data,
  output logic [NPORT-1:0]            err_drop
);

  localparam int unsigned PW = pw_of(WIDTH, XH, YH);
  localparam int unsigned YL = yhop_lsb(WIDTH, XH, YH);
  localparam int unsigned XL = xhop_lsb(WIDTH, XH, YH);

  // Reject parameter sets the packet layout or FIFO cannot support.
  if (WIDTH < 3 + XH + YH || WIDTH >= MAXW || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || NODE_NUM < 0) begin : g_param_err
    $error("router_mesh_sync: unsupported parameters");
  end

  logic [NPORT-1:0]  push_c;
  logic [NPORT-1:0]  pop_c;
  logic [NPORT-1:0]  full_c;
  logic [NPORT-1:0]  empty_c;
  logic [NPORT-1:0]  drop_c;
  logic [NPORT-1:0]  req_c [NPORT];
  route_t            route_c [NPORT];
  logic [NPORT-1:0]  gnt_vld_c;
  logic [PORT_W-1:0] gnt_idx_c [NPORT];
  logic [PORT_W-1:0] ptr [NPORT];

  assign in_ready = ~full_c & {NPORT{~rst}};
  assign push_c   = in_valid & in_ready;

  for (genvar p = 0; p < NPORT; p++) begin : g_in
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             xdir;
    logic             ydir;
    logic [XH-1:0]    xhop;
    logic [YH-1:0]    yhop;
    logic [WIDTH-1:0] pkt_c;
    route_t           rt;
    logic             unused_hi;

    router_in_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c[p]),
      .pop   (pop_c[p]),
      .din   (in_data[p]),
      .head  (head),
      .full  (full),
      .empty (empty)
    );

    assign full_c[p]  = full;
    assign empty_c[p] = empty;

    // XY route of the head: X first, then Y, else eject with header stripped.
    always_comb begin
      xdir        = head[WIDTH-1];
      ydir        = head[WIDTH-2];
      xhop        = head[XL +: XH];
      yhop        = head[YL +: YH];
      pkt_c       = head;
      rt.out_port = P_PE;
      rt.new_pkt  = MAXW'(head[PW-1:0]);
      if (hop_nz(HOPW'(xhop))) begin
        rt.out_port        = xdir ? P_E : P_W;
        pkt_c[XL +: XH]    = XH'(hop_dec(HOPW'(xhop)));
        rt.new_pkt         = MAXW'(pkt_c);
      end else if (hop_nz(HOPW'(yhop))) begin
        rt.out_port        = ydir ? P_S : P_N;
        pkt_c[YL +: YH]    = YH'(hop_dec(HOPW'(yhop)));
        rt.new_pkt         = MAXW'(pkt_c);
      end
      rt.legal = (rt.out_port != port_e'(PORT_W'(p))) &&
                 !(((p == int'(P_N)) || (p == int'(P_S))) && hop_nz(HOPW'(xhop)));
    end

    assign route_c[p] = rt;
    assign drop_c[p]  = !empty && !rt.legal;
    assign req_c[p]   = (!empty && rt.legal) ? (NPORT'(1) << rt.out_port) : '0;
    assign unused_hi  = ^rt.new_pkt[MAXW-1:WIDTH];
  end

  // Round-robin grant per loadable output; granted and dropped heads pop.
  always_comb begin
    pop_c = drop_c;
    for (int o = 0; o < NPORT; o++) begin
      gnt_vld_c[o] = 1'b0;
      gnt_idx_c[o] = '0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int unsigned k = 0; k < NPORT; k++) begin
          if (!gnt_vld_c[o] && req_c[rr_idx(ptr[o], k)][o]) begin
            gnt_vld_c[o] = 1'b1;
            gnt_idx_c[o] = rr_idx(ptr[o], k);
          end
        end
      end
      for (int p = 0; p < NPORT; p++) begin
        if (gnt_vld_c[o] && (gnt_idx_c[o] == PORT_W'(p))) pop_c[p] = 1'b1;
      end
    end
  end

  // Output registers, round-robin pointers and drop pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      err_drop  <= '0;
      for (int o = 0; o < NPORT; o++) ptr[o] <= '0;
    end else begin
      err_drop <= drop_c;
      for (int o = 0; o < NPORT; o++) begin
        if (!out_valid[o] || out_ready[o]) begin
          out_valid[o] <= gnt_vld_c[o];
          if (gnt_vld_c[o]) begin
            out_data[o] <= route_c[gnt_idx_c[o]].new_pkt[WIDTH-1:0];
            ptr[o]      <= rr_next(gnt_idx_c[o]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_router_mesh_sync.sv
// Directed scoreboard bench for router_mesh_sync (WIDTH=20, XH=YH=3, DEPTH=4).
module tb_router_mesh_sync;

  localparam int W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        in_valid;
  logic [4:0]        in_ready;
  logic [4:0][W-1:0] in_data;
  logic [4:0]        out_valid;
  logic [4:0]        out_ready;
  logic [4:0][W-1:0] out_data;
  logic [4:0]        err_drop;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [5][$];
  int exp_drop [5];

  bit [4:0]        pv;
  bit [4:0]        pr;
  bit [4:0][W-1:0] pd;
  bit              prst;

  always #5 clk = ~clk;

  router_mesh_sync #(.WIDTH(20), .XH(3), .YH(3), .DEPTH(4), .NODE_NUM(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_drop  (err_drop)
  );

  function automatic logic [W-1:0] mk(logic xd, logic yd, logic [2:0] xh, logic [2:0] yh,
                                      logic [11:0] pl);
    return {xd, yd, xh, yh, pl};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pending();
    for (int o = 0; o < 5; o++)
      if (exp_q[o].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: scoreboard pops on every output transfer, drop pulses, hold-under-stall.
  always @(negedge clk) begin
    for (int o = 0; o < 5; o++) begin
      if (!rst && !prst && pv[o] && !pr[o]) begin
        chk($sformatf("hold_valid_%0d", o), 64'(out_valid[o]), 64'(1));
        chk($sformatf("hold_data_%0d", o), 64'(out_data[o]), 64'(pd[o]));
      end
      if (!rst && out_valid[o] && out_ready[o]) begin
        if (exp_q[o].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_%0d: got %0h expected nothing", o, out_data[o]);
        end else begin
          chk($sformatf("out_data_%0d", o), 64'(out_data[o]), 64'(exp_q[o].pop_front()));
        end
      end
      if (err_drop[o]) begin
        checks++;
        if (exp_drop[o] > 0) exp_drop[o]--;
        else begin
          errors++;
          $display("FAIL unexpected_drop_%0d: got 1 expected 0", o);
        end
      end
    end
    pv   = out_valid;
    pr   = out_ready;
    pd   = out_data;
    prst = rst;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '1;
    for (int o = 0; o < 5; o++) exp_drop[o] = 0;

    // Reset state
    cyc();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_err_drop", 64'(err_drop), 64'(0));
    cyc();
    rst = 1'b0;
    cyc();
    chk("idle_in_ready", 64'(in_ready), 64'(5'h1f));

    // Single x-hop W -> E with one-cycle transit
    exp_q[1].push_back(mk(1'b1, 1'b0, 3'b001, 3'b000, 12'habc));
    in_valid[0] = 1'b1;
    in_data[0]  = mk(1'b1, 1'b0, 3'b011, 3'b000, 12'habc);
    cyc();
    in_valid = '0;
    chk("xhop_lat0", 64'(out_valid), 64'(0));
    cyc();
    chk("xhop_lat1", 64'(out_valid), 64'(5'b00010));
    cyc();
    cyc();

    // Ejection S -> PE with header stripped
    exp_q[4].push_back(20'h005A5);
    in_valid[3] = 1'b1;
    in_data[3]  = mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h5a5);
    cyc();
    in_valid = '0;
    cyc();
    chk("eject_only_pe", 64'(out_valid), 64'(5'b10000));
    cyc();
    cyc();

    // Contention on N, pointer at 0: W, E, PE
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h111));
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h222));
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h333));
    in_valid   = 5'b10011;
    in_data[0] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h111);
    in_data[1] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h222);
    in_data[4] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h333);
    cyc();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("cont0_valid_%0d", k), 64'(out_valid), 64'(5'b00100));
    end
    cyc();
    chk("cont0_done", 64'(out_valid), 64'(0));

    // Move N pointer to 1 with a lone W packet
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h444));
    in_valid[0] = 1'b1;
    in_data[0]  = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h444);
    cyc();
    in_valid = '0;
    cyc();
    cyc();

    // Contention on N, pointer at 1: E, PE, W
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h555));
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h666));
    exp_q[2].push_back(mk(1'b0, 1'b0, 3'b000, 3'b000, 12'h777));
    in_valid   = 5'b10011;
    in_data[0] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h777);
    in_data[1] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h555);
    in_data[4] = mk(1'b0, 1'b0, 3'b000, 3'b001, 12'h666);
    cyc();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("cont1_valid_%0d", k), 64'(out_valid), 64'(5'b00100));
    end
    cyc();
    cyc();

    // Back-pressure: 1 in the output register + 4 in the W FIFO
    out_ready[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q[1].push_back(mk(1'b1, 1'b0, 3'b000, 3'b000, 12'(12'h100 + k)));
      in_valid[0] = 1'b1;
      in_data[0]  = mk(1'b1, 1'b0, 3'b001, 3'b000, 12'(12'h100 + k));
      chk($sformatf("bp_accept_%0d", k), 64'(in_ready[0]), 64'(1));
      cyc();
    end
    in_valid = '0;
    chk("bp_full", 64'(in_ready[0]), 64'(0));
    chk("bp_out_held", 64'(out_valid[1]), 64'(1));
    cyc();
    cyc();
    cyc();
    chk("bp_still_full", 64'(in_ready[0]), 64'(0));
    out_ready[1] = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("bp_drained", 64'(in_ready[0]), 64'(1));

    // Illegal heads: E U-turn, N with xhop, PE -> PE
    exp_drop[1]++;
    exp_drop[2]++;
    exp_drop[4]++;
    in_valid   = 5'b10110;
    in_data[1] = mk(1'b1, 1'b0, 3'b001, 3'b000, 12'heee);
    in_data[2] = mk(1'b1, 1'b0, 3'b001, 3'b000, 12'hddd);
    in_data[4] = mk(1'b0, 1'b0, 3'b000, 3'b000, 12'hccc);
    cyc();
    in_valid = '0;
    cyc();
    chk("drop_pulse", 64'(err_drop), 64'(5'b10110));
    chk("drop_no_out", 64'(out_valid), 64'(0));
    cyc();
    chk("drop_clear", 64'(err_drop), 64'(0));
    cyc();

    // Reset with 3 packets in flight (1 in E output register, 2 in W FIFO)
    out_ready = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = mk(1'b1, 1'b0, 3'b001, 3'b000, 12'(12'h900 + k));
      cyc();
    end
    in_valid = '0;
    cyc();
    chk("mid_out_loaded", 64'(out_valid), 64'(5'b00010));
    rst = 1'b1;
    cyc();
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    chk("mid_rst_out_data", 64'(out_data[1]), 64'(0));
    rst       = 1'b0;
    out_ready = '1;
    cyc();
    chk("mid_post_in_ready", 64'(in_ready), 64'(5'h1f));
    cyc();
    cyc();
    chk("mid_post_empty", 64'(out_valid), 64'(0));
    exp_q[1].push_back(mk(1'b1, 1'b0, 3'b000, 3'b000, 12'haaa));
    in_valid[0] = 1'b1;
    in_data[0]  = mk(1'b1, 1'b0, 3'b001, 3'b000, 12'haaa);
    cyc();
    in_valid = '0;

    // Drain and final accounting
    for (int i = 0; i < 50 && pending(); i++) cyc();
    cyc();
    cyc();
    for (int o = 0; o < 5; o++) begin
      chk($sformatf("final_queue_%0d", o), 64'(exp_q[o].size()), 64'(0));
      chk($sformatf("final_drop_%0d", o), 64'(exp_drop[o]), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
